traffic_fsm: RTL and testbench

- Upstream controller for the two-road light decoder.
- Produces the 3-bit phase code s[2:0]; the downstream decoder turns that code into the lA/lB light pairs.
- Owns all timing: a clock prescaler, a per-phase dwell counter, sensor synchronisers and an 8-state Moore FSM sequencing road A and road B.

---
 rtl/traffic_fsm.sv | 71 +++++++
 tb/tb_traffic_fsm.sv | 131 +++++++++++++
 2 files changed

// File: rtl/traffic_fsm.sv
// traffic_fsm: two-road light sequencer producing phase code s with 1 s tick prescaler, dwell timing and sensor sync
module traffic_fsm #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int PHASE_SEC     = 3,
    parameter int MIN_GREEN_SEC = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sa,
    input  logic       sb,
    output logic [2:0] s,
    output logic       tick
);
    localparam int MAXD = (PHASE_SEC > MIN_GREEN_SEC) ? PHASE_SEC : MIN_GREEN_SEC;
    localparam int DW   = $clog2(MAXD + 1);
    localparam int CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    state_t        st;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DW-1:0] dwell;
    logic [1:0]    sa_q, sb_q;
    logic          sa_s, sb_s, green_ok, timed_done, adv;

    assign s          = st;
    assign sa_s       = sa_q[1];
    assign sb_s       = sb_q[1];
    assign cnt_nx     = (cnt == CW'(CLK_FREQ - 1)) ? '0 : cnt + 1'b1;
    assign green_ok   = dwell >= DW'(MIN_GREEN_SEC - 1);
    assign timed_done = dwell == DW'(PHASE_SEC - 1);

    // Greens wait for a one-sided request after the minimum hold; every other phase is purely timed
    always_comb begin
        adv = (st == S0) ? (green_ok && sb_s && !sa_s) :
              (st == S4) ? (green_ok && sa_s && !sb_s) : timed_done;
    end

    // Free-running prescaler; tick is registered so it is high exactly while cnt sits at its top value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            tick <= (cnt_nx == CW'(CLK_FREQ - 1));
        end
    end

    // Two-flop synchronisers for the asynchronous road sensors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q <= '0;
            sb_q <= '0;
        end else begin
            sa_q <= {sa_q[0], sa};
            sb_q <= {sb_q[0], sb};
        end
    end

    // Phase sequencer and dwell counter; both move only on tick cycles, dwell saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S0;
            dwell <= '0;
        end else if (tick) begin
            st    <= adv ? state_t'(st + 3'd1) : st;
            dwell <= adv ? '0 : (&dwell ? dwell : dwell + 1'b1);
        end
    end
endmodule

// File: tb/tb_traffic_fsm.sv
// tb_traffic_fsm: directed checks of the traffic phase sequencer with CLK_FREQ=4, PHASE_SEC=3, MIN_GREEN_SEC=2
module tb_traffic_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sa = 1'b0;
    logic       sb = 1'b0;
    logic [2:0] s;
    logic       tick;
    int         n_assert = 0;
    int         n_fail = 0;
    int         p = 0;
    int         exp2 [12] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4};
    int         exp3 [10] = '{5, 5, 5, 6, 6, 6, 7, 7, 7, 0};

    traffic_fsm #(.CLK_FREQ(4), .PHASE_SEC(3), .MIN_GREEN_SEC(2)) dut (
        .clk(clk), .rst_n(rst_n), .sa(sa), .sb(sb), .s(s), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // p counts rising edges since reset release; tick is due whenever p mod 4 == 3
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            p++;
            chk("tick", {31'd0, tick}, {31'd0, (p % 4) == 3});
        end
    endtask

    task automatic do_reset(input logic sa_v, input logic sb_v);
        rst_n = 1'b0;
        sa = sa_v;
        sb = sb_v;
        repeat (2) @(negedge clk);
        chk("rst_s", {29'd0, s}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        rst_n = 1'b1;
        p = 0;
    endtask

    task automatic run_seq2(input string tag);
        for (int k = 0; k < 12; k++) begin
            cyc(4);
            chk(tag, {29'd0, s}, exp2[k]);
        end
    endtask

    initial begin
        // Scenario 1: only road A requests, so the green never leaves A
        do_reset(1'b1, 1'b0);
        cyc(3);
        chk("first_tick", {31'd0, tick}, 32'd1);
        cyc(1);
        chk("s1_hold", {29'd0, s}, 32'd0);
        for (int k = 0; k < 49; k++) begin
            cyc(4);
            chk("s1_hold", {29'd0, s}, 32'd0);
        end
        // Scenario 2: road B requests from reset; S4 held while B still requests
        do_reset(1'b0, 1'b1);
        run_seq2("s2_seq");
        cyc(8);
        chk("s2_hold4", {29'd0, s}, 32'd4);
        // Scenario 3: swap the request to road A, walk 5,6,7 and wrap to 0
        sa = 1'b1;
        sb = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(4);
            chk("s3_seq", {29'd0, s}, exp3[k]);
        end
        // Scenario 4: both roads requesting holds S0, then B alone advances on the next tick
        sb = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(4);
            chk("s4_both", {29'd0, s}, 32'd0);
        end
        sa = 1'b0;
        cyc(4);
        chk("s4_adv", {29'd0, s}, 32'd1);
        // Scenario 5a: sb seen on the first tick only, before the minimum green has elapsed
        do_reset(1'b0, 1'b0);
        sb = 1'b1;
        cyc(3);
        sb = 1'b0;
        cyc(1);
        chk("s5_mingreen", {29'd0, s}, 32'd0);
        cyc(4);
        chk("s5_mingreen", {29'd0, s}, 32'd0);
        // Scenario 5b: two-cycle sb pulse whose synchronised copy falls between ticks
        cyc(3);
        sb = 1'b1;
        cyc(2);
        sb = 1'b0;
        cyc(3);
        chk("s5_gap", {29'd0, s}, 32'd0);
        cyc(8);
        chk("s5_gap", {29'd0, s}, 32'd0);
        // Scenario 6: asynchronous reset in the middle of S2, then the scenario 2 timing again
        do_reset(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(4);
            chk("s6_pre", {29'd0, s}, exp2[k]);
        end
        cyc(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_s", {29'd0, s}, 32'd0);
        chk("s6_async_tick", {31'd0, tick}, 32'd0);
        do_reset(1'b0, 1'b1);
        cyc(3);
        chk("s6_first_tick", {31'd0, tick}, 32'd1);
        cyc(1);
        chk("s6_seq", {29'd0, s}, 32'd0);
        for (int k = 1; k < 12; k++) begin
            cyc(4);
            chk("s6_seq", {29'd0, s}, exp2[k]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
